axi_aw_route_decoder: RTL and testbench
=======================================

# axi_aw_route_decoder

Write-address routing stage of the AXI node slave port. Decodes each AW address against per-master-port region tables, forwards AW to exactly one init port, and pushes the one-hot destination into the W-channel decoder's destination FIFO. Unmapped addresses are absorbed locally: the block drains the burst's W beats through the W decoder's error path and returns a DECERR write response. It sits directly upstream of the W-channel destination decoder and drives that decoder's `DEST`/`push`/`handle_error` inputs.

## Interface
- `ADDR_WIDTH`, 32, AW address width
- `AXI_ID`, 6, AW/B ID width
- `N_INIT_PORT`, 4, number of master-side ports
- `N_REGION`, 2, address regions per port
- `MAX_OUTSTANDING`, 8, maximum routed bursts whose W data is not yet complete; `CNT_W = $clog2(MAX_OUTSTANDING+1)`

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `awvalid_i` in 1: slave-side AW valid
- `awaddr_i` in ADDR_WIDTH: slave-side AW address
- `awid_i` in AXI_ID: slave-side AW ID
- `awready_o` out 1: slave-side AW ready
- `awvalid_o` out N_INIT_PORT: per-port AW valid, at most one bit set
- `awready_i` in N_INIT_PORT: per-port AW ready
- `START_ADDR_i` in N_REGION*N_INIT_PORT*ADDR_WIDTH: region start, inclusive
- `END_ADDR_i` in N_REGION*N_INIT_PORT*ADDR_WIDTH: region end, inclusive
- `enable_region_i` in N_REGION*N_INIT_PORT: region enable
- `connectivity_map_i` in N_INIT_PORT: port reachable from this slave port
- `grant_FIFO_DEST_i` in 1: W destination FIFO not full
- `DEST_o` out N_INIT_PORT: one-hot destination
- `push_DEST_o` out 1: destination FIFO push
- `w_last_hs_i` in 1: slave-side W handshake with `wlast` on a routed burst
- `handle_error_o` out 1: W decoder error-drain request
- `wdata_error_completed_i` in 1: W decoder reports the last error beat consumed
- `berr_valid_o` out 1: error B valid
- `berr_id_o` out AXI_ID: error B ID
- `berr_resp_o` out 2: error B response, constant `2'b11` (DECERR)
- `berr_ready_i` in 1: error B ready

## Operation
- Region index is `r*N_INIT_PORT + p`. `hit[p] = connectivity_map_i[p] & OR_r(enable_region_i & START <= awaddr_i <= END)`. Comparisons are unsigned.
- Multiple hits: the lowest `p` wins. `DEST_o` is the one-hot of the winner. No hit means a decode error.
- `cnt`: outstanding routed bursts. +1 on `push_DEST_o`, -1 on `w_last_hs_i`. A simultaneous +1 and -1 leaves it unchanged. A decrement at 0 is ignored.
- FSM states: IDLE, WAIT_W, DRAIN, RESP.
- IDLE with a hit:
  - Define `ok = grant_FIFO_DEST_i & (cnt < MAX_OUTSTANDING)`.
  - `awvalid_o = DEST_o & {N{awvalid_i & ok}}`.
  - `awready_o = |(awready_i & DEST_o) & ok`.
  - `push_DEST_o = awvalid_i & awready_o`.
- IDLE with no hit and `awvalid_i`:
  - `awready_o = 1`, `awvalid_o = 0`, no push.
  - Capture `awid_i` into `berr_id_o`.
  - Go to WAIT_W.
- WAIT_W: `awready_o = 0`. Go to DRAIN when `cnt == 0`, including the cycle `cnt` reaches 0.
- DRAIN: `handle_error_o = 1`. Go to RESP on `wdata_error_completed_i`.
- RESP: `berr_valid_o = 1`; `berr_id_o` is stable. Go to IDLE on `berr_ready_i`.
- Outside IDLE: `awready_o = 0`, `awvalid_o = 0`, `push_DEST_o = 0`.

## Timing
- The route path is combinational from `awvalid_i`/`awaddr_i` to `awvalid_o`/`awready_o`/`push_DEST_o`: 0-cycle latency.
- Valid is never gated by the ready it receives: `awvalid_o` does not depend on `awready_i`.
- An error burst takes at least 3 cycles from the AW handshake to `berr_valid_o`: WAIT_W, then DRAIN, then RESP.
- `berr_valid_o` holds until `berr_ready_i`. The next AW is accepted no earlier than the cycle after the B handshake.
- `rst` asserted values:
  - FSM = IDLE, `cnt = 0`, `berr_id_o = 0`.
  - `handle_error_o = 0`, `berr_valid_o = 0`.
  - `awready_o = 0`, `awvalid_o = 0`, `push_DEST_o = 0` while `rst` is high.
- Reset mid-burst abandons all state; nothing is replayed.
- `cnt == MAX_OUTSTANDING` stalls hits and leaves misses unaffected.

## Configuration
- `AXI_AW_DEFAULT_SLAVE_EN` defined:
  - A miss routes to port `N_INIT_PORT-1` through the normal IDLE path, still gated by `connectivity_map_i`. If that port is unreachable, the miss is a decode error.
  - The FSM otherwise never leaves IDLE.
- `AXI_AW_DEFAULT_SLAVE_EN` undefined: misses follow the error FSM above.

## Test plan
- Hit on port 2 (region 0: 0x2000_0000–0x2FFF_FFFF), `awaddr_i = 0x2000_0010`, `awready_i = 4'b0100` -> `awvalid_o = 4'b0100`, same-cycle `awready_o = 1`, `push_DEST_o = 1`, `DEST_o = 4'b0100`, `cnt` 0 -> 1.
- Overlapping regions on ports 1 and 3 -> `DEST_o = 4'b0010`. Clearing `connectivity_map_i[1]` -> `DEST_o = 4'b1000`.
- `grant_FIFO_DEST_i = 0` with a valid hit -> `awvalid_o = 0`, `awready_o = 0`. Raising it -> the handshake completes in that cycle.
- Miss with `cnt = 2`, `awid_i = 0x15` -> AW accepted, WAIT_W until two `w_last_hs_i`, then DRAIN with `handle_error_o = 1` until completion. Then `berr_valid_o = 1`, `berr_id_o = 0x15`, `berr_resp_o = 2'b11`, held 4 cycles with `berr_ready_i = 0`, then IDLE.
- Eight routed bursts without W completion -> ninth hit stalled. `w_last_hs_i` concurrent with a ninth push -> `cnt` stays 8.
- `rst` pulsed during DRAIN -> `handle_error_o` drops asynchronously, FSM IDLE, `cnt = 0`. The next hit routes normally.

Source files
------------

// File: rtl/axi_aw_route_decoder.sv
// AW routing stage: region decode, one-hot port select, destination FIFO push and DECERR handling for unmapped bursts.
// Optional macro AXI_AW_DEFAULT_SLAVE_EN sends misses to port N_INIT_PORT-1 instead of the error path.
module axi_aw_route_decoder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_ID          = 6,
  parameter int N_INIT_PORT     = 4,
  parameter int N_REGION        = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      awvalid_i,
  input  logic [ADDR_WIDTH-1:0]                     awaddr_i,
  input  logic [AXI_ID-1:0]                         awid_i,
  output logic                                      awready_o,
  output logic [N_INIT_PORT-1:0]                    awvalid_o,
  input  logic [N_INIT_PORT-1:0]                    awready_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]           enable_region_i,
  input  logic [N_INIT_PORT-1:0]                    connectivity_map_i,
  input  logic                                      grant_FIFO_DEST_i,
  output logic [N_INIT_PORT-1:0]                    DEST_o,
  output logic                                      push_DEST_o,
  input  logic                                      w_last_hs_i,
  output logic                                      handle_error_o,
  input  logic                                      wdata_error_completed_i,
  output logic                                      berr_valid_o,
  output logic [AXI_ID-1:0]                         berr_id_o,
  output logic [1:0]                                berr_resp_o,
  input  logic                                      berr_ready_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_W = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [AXI_ID-1:0]       berr_id_q, berr_id_d;
  logic [N_INIT_PORT-1:0]  hit_s;
  logic [N_INIT_PORT-1:0]  dest_s;
  logic                    found_s;
  logic                    route_s;
  logic                    ok_s;
  logic [N_INIT_PORT-1:0]  awvalid_s;
  logic                    awready_s;
  logic                    push_s;

  // Per-port region match, masked by reachability.
  always_comb begin
    hit_s = '0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      for (int r = 0; r < N_REGION; r++) begin
        if (connectivity_map_i[p] && enable_region_i[r*N_INIT_PORT+p] &&
            (awaddr_i >= START_ADDR_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (awaddr_i <= END_ADDR_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH])) begin
          hit_s[p] = 1'b1;
        end else begin
          hit_s[p] = hit_s[p];
        end
      end
    end
  end

  // Lowest-numbered hitting port wins; optional default-slave fallback.
  always_comb begin
    dest_s  = '0;
    found_s = 1'b0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      if (hit_s[p] && !found_s) begin
        dest_s[p] = 1'b1;
        found_s   = 1'b1;
      end else begin
        dest_s[p] = dest_s[p];
      end
    end
`ifdef AXI_AW_DEFAULT_SLAVE_EN
    if (!found_s && connectivity_map_i[N_INIT_PORT-1]) begin
      dest_s[N_INIT_PORT-1] = 1'b1;
    end else begin
      dest_s = dest_s;
    end
`endif
  end

  assign route_s = |dest_s;
  assign ok_s    = grant_FIFO_DEST_i & (cnt_q < CNT_MAX);

  // Combinational AW handshake; valid never looks at the downstream ready.
  always_comb begin
    awvalid_s = '0;
    awready_s = 1'b0;
    push_s    = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (route_s) begin
        awvalid_s = dest_s & {N_INIT_PORT{awvalid_i & ok_s}};
        awready_s = (|(awready_i & dest_s)) & ok_s;
        push_s    = awvalid_i & awready_s;
      end else begin
        awready_s = awvalid_i;
      end
    end else begin
      awready_s = 1'b0;
    end
  end

  // Outstanding routed-burst counter; a decrement at zero is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (push_s && !w_last_hs_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!push_s && w_last_hs_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Error FSM: wait for routed W traffic to finish, drain the error burst, answer DECERR.
  always_comb begin
    state_d   = state_q;
    berr_id_d = berr_id_q;
    case (state_q)
      IDLE: begin
        if (!route_s && awvalid_i) begin
          state_d   = WAIT_W;
          berr_id_d = awid_i;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_W: begin
        if (cnt_d == '0) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT_W;
        end
      end
      DRAIN: begin
        if (wdata_error_completed_i) begin
          state_d = RESP;
        end else begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (berr_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and captured error ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      berr_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      berr_id_q <= berr_id_d;
    end
  end

  assign awvalid_o      = awvalid_s;
  assign awready_o      = awready_s;
  assign push_DEST_o    = push_s;
  assign DEST_o         = dest_s;
  assign handle_error_o = (state_q == DRAIN);
  assign berr_valid_o   = (state_q == RESP);
  assign berr_id_o      = berr_id_q;
  assign berr_resp_o    = 2'b11;

endmodule

// File: tb/tb_axi_aw_route_decoder.sv
// Scoreboard bench for axi_aw_route_decoder (default build, no default slave).
module tb_axi_aw_route_decoder;
  localparam int AW  = 32;
  localparam int IDW = 6;
  localparam int N   = 4;
  localparam int R   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              awvalid_i;
  logic [AW-1:0]     awaddr_i;
  logic [IDW-1:0]    awid_i;
  logic              awready_o;
  logic [N-1:0]      awvalid_o;
  logic [N-1:0]      awready_i;
  logic [R*N*AW-1:0] START_ADDR_i;
  logic [R*N*AW-1:0] END_ADDR_i;
  logic [R*N-1:0]    enable_region_i;
  logic [N-1:0]      connectivity_map_i;
  logic              grant_FIFO_DEST_i;
  logic [N-1:0]      DEST_o;
  logic              push_DEST_o;
  logic              w_last_hs_i;
  logic              handle_error_o;
  logic              wdata_error_completed_i;
  logic              berr_valid_o;
  logic [IDW-1:0]    berr_id_o;
  logic [1:0]        berr_resp_o;
  logic              berr_ready_i;

  int errors = 0;
  int checks = 0;
  logic [N-1:0]   dq[$];
  logic [IDW-1:0] bq[$];

  axi_aw_route_decoder dut (
    .clk(clk), .rst(rst),
    .awvalid_i(awvalid_i), .awaddr_i(awaddr_i), .awid_i(awid_i), .awready_o(awready_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .START_ADDR_i(START_ADDR_i), .END_ADDR_i(END_ADDR_i),
    .enable_region_i(enable_region_i), .connectivity_map_i(connectivity_map_i),
    .grant_FIFO_DEST_i(grant_FIFO_DEST_i), .DEST_o(DEST_o), .push_DEST_o(push_DEST_o),
    .w_last_hs_i(w_last_hs_i), .handle_error_o(handle_error_o),
    .wdata_error_completed_i(wdata_error_completed_i),
    .berr_valid_o(berr_valid_o), .berr_id_o(berr_id_o), .berr_resp_o(berr_resp_o),
    .berr_ready_i(berr_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Destination scoreboard: every push must match the next expected one-hot.
  always @(negedge clk) begin
    if (!rst && push_DEST_o) begin
      if (dq.size() == 0) check_eq("dest_sb_pending", dq.size(), 1);
      else check_eq("dest_sb", DEST_o, dq.pop_front());
    end
  end

  // Error-response scoreboard, compared on the B handshake.
  always @(negedge clk) begin
    if (!rst && berr_valid_o && berr_ready_i) begin
      check_eq("berr_resp", berr_resp_o, 2'b11);
      if (bq.size() == 0) check_eq("berr_sb_pending", bq.size(), 1);
      else check_eq("berr_id_sb", berr_id_o, bq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_region(input int r, input int p, input logic [31:0] s, input logic [31:0] e);
    START_ADDR_i[(r*N+p)*AW +: AW] = s;
    END_ADDR_i[(r*N+p)*AW +: AW]   = e;
    enable_region_i[r*N+p]         = 1'b1;
  endtask

  task automatic hit(input logic [31:0] a, input logic [N-1:0] rdy, input logic [N-1:0] exp, input string tag);
    tick();
    awvalid_i = 1'b1;
    awaddr_i  = a;
    awready_i = rdy;
    dq.push_back(exp);
    @(negedge clk);
    check_eq({tag, "_awvalid"}, awvalid_o, exp);
    check_eq({tag, "_awready"}, awready_o, 1'b1);
    check_eq({tag, "_push"}, push_DEST_o, 1'b1);
    tick();
    awvalid_i = 1'b0;
    awready_i = '0;
  endtask

  task automatic wlast_cycles(input int n);
    tick();
    w_last_hs_i = 1'b1;
    repeat (n - 1) tick();
    tick();
    w_last_hs_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awvalid_i = 1'b1; awaddr_i = 32'h2000_0010; awid_i = '0; awready_i = 4'b1111;
    START_ADDR_i = '0; END_ADDR_i = '0; enable_region_i = '0;
    connectivity_map_i = 4'b1111; grant_FIFO_DEST_i = 1'b1;
    w_last_hs_i = 1'b0; wdata_error_completed_i = 1'b0; berr_ready_i = 1'b0;
    set_region(0, 2, 32'h2000_0000, 32'h2FFF_FFFF);
    set_region(0, 1, 32'h4000_0000, 32'h4FFF_FFFF);
    set_region(1, 3, 32'h4000_0000, 32'h5FFF_FFFF);
    set_region(0, 0, 32'h0000_0000, 32'h0FFF_FFFF);

    @(negedge clk);
    check_eq("rst_awvalid", awvalid_o, 4'b0000);
    check_eq("rst_awready", awready_o, 1'b0);
    check_eq("rst_push", push_DEST_o, 1'b0);
    check_eq("rst_handle_err", handle_error_o, 1'b0);
    check_eq("rst_berr_valid", berr_valid_o, 1'b0);
    check_eq("rst_berr_id", berr_id_o, 6'h00);
    awvalid_i = 1'b0; awready_i = '0;
    @(negedge clk);
    rst = 1'b0;

    hit(32'h2000_0010, 4'b0100, 4'b0100, "hit_p2");
    hit(32'h4000_0100, 4'b0010, 4'b0010, "overlap_p1");
    connectivity_map_i = 4'b1101;
    hit(32'h4000_0100, 4'b1000, 4'b1000, "overlap_p3");
    connectivity_map_i = 4'b1111;

    // Valid independent of downstream ready.
    tick();
    awvalid_i = 1'b1; awaddr_i = 32'h2000_0010; awready_i = 4'b0000;
    @(negedge clk);
    check_eq("noready_awvalid", awvalid_o, 4'b0100);
    check_eq("noready_awready", awready_o, 1'b0);

    // FIFO full blocks, then grant completes in-cycle.
    tick();
    grant_FIFO_DEST_i = 1'b0; awaddr_i = 32'h0000_1000; awready_i = 4'b0001;
    @(negedge clk);
    check_eq("nogrant_awvalid", awvalid_o, 4'b0000);
    check_eq("nogrant_awready", awready_o, 1'b0);
    tick();
    grant_FIFO_DEST_i = 1'b1;
    dq.push_back(4'b0001);
    @(negedge clk);
    check_eq("grant_awvalid", awvalid_o, 4'b0001);
    check_eq("grant_awready", awready_o, 1'b1);
    tick();
    awvalid_i = 1'b0; awready_i = '0;

    wlast_cycles(2);  // four routed -> two outstanding

    // Miss with two bursts still outstanding.
    tick();
    awvalid_i = 1'b1; awaddr_i = 32'h8000_0000; awid_i = 6'h15; awready_i = 4'b1111;
    bq.push_back(6'h15);
    @(negedge clk);
    check_eq("miss_awready", awready_o, 1'b1);
    check_eq("miss_awvalid", awvalid_o, 4'b0000);
    check_eq("miss_push", push_DEST_o, 1'b0);
    tick();
    awaddr_i = 32'h2000_0010; awid_i = 6'h00;
    @(negedge clk);
    check_eq("waitw_awready", awready_o, 1'b0);
    check_eq("waitw_awvalid", awvalid_o, 4'b0000);
    check_eq("waitw_handle", handle_error_o, 1'b0);
    tick();
    awvalid_i = 1'b0; w_last_hs_i = 1'b1;
    @(negedge clk);
    check_eq("waitw1_handle", handle_error_o, 1'b0);
    tick();
    @(negedge clk);
    check_eq("waitw2_handle", handle_error_o, 1'b0);
    tick();
    w_last_hs_i = 1'b0;
    @(negedge clk);
    check_eq("drain_handle", handle_error_o, 1'b1);
    check_eq("drain_berr_valid", berr_valid_o, 1'b0);
    tick();
    @(negedge clk);
    check_eq("drain2_handle", handle_error_o, 1'b1);
    tick();
    wdata_error_completed_i = 1'b1;
    @(negedge clk);
    check_eq("drain3_handle", handle_error_o, 1'b1);
    tick();
    wdata_error_completed_i = 1'b0;
    awvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("resp_berr_valid", berr_valid_o, 1'b1);
      check_eq("resp_berr_id", berr_id_o, 6'h15);
      check_eq("resp_handle", handle_error_o, 1'b0);
      check_eq("resp_awready", awready_o, 1'b0);
      tick();
    end
    berr_ready_i = 1'b1;
    @(negedge clk);
    check_eq("bhs_berr_valid", berr_valid_o, 1'b1);
    tick();
    berr_ready_i = 1'b0;
    awready_i = 4'b0100;
    dq.push_back(4'b0100);
    @(negedge clk);
    check_eq("post_b_berr_valid", berr_valid_o, 1'b0);
    check_eq("post_b_awready", awready_o, 1'b1);
    tick();
    awvalid_i = 1'b0;
    wlast_cycles(1);

    // Fill to the outstanding limit.
    for (int i = 0; i < 8; i++) begin
      tick();
      awvalid_i = 1'b1; awaddr_i = 32'h2000_0010; awready_i = 4'b0100;
      dq.push_back(4'b0100);
      @(negedge clk);
      check_eq("fill_awready", awready_o, 1'b1);
    end
    tick();
    @(negedge clk);
    check_eq("stall9_awready", awready_o, 1'b0);
    check_eq("stall9_awvalid", awvalid_o, 4'b0000);
    tick();
    w_last_hs_i = 1'b1;
    @(negedge clk);
    check_eq("stall_wlast_awready", awready_o, 1'b0);
    tick();
    dq.push_back(4'b0100);
    @(negedge clk);
    check_eq("conc_awready", awready_o, 1'b1);
    tick();
    w_last_hs_i = 1'b0;
    dq.push_back(4'b0100);
    @(negedge clk);
    check_eq("refill_awready", awready_o, 1'b1);
    tick();
    @(negedge clk);
    check_eq("stall_conc_awready", awready_o, 1'b0);
    tick();
    awvalid_i = 1'b0;
    wlast_cycles(8);
    wlast_cycles(1);  // decrement at zero must be ignored

    for (int i = 0; i < 8; i++) begin
      tick();
      awvalid_i = 1'b1; awaddr_i = 32'h2000_0010; awready_i = 4'b0100;
      dq.push_back(4'b0100);
      @(negedge clk);
      check_eq("fill0_awready", awready_o, 1'b1);
    end
    tick();
    @(negedge clk);
    check_eq("stall0_awready", awready_o, 1'b0);
    tick();
    awvalid_i = 1'b0;
    wlast_cycles(8);

    // Reset while draining an error burst.
    tick();
    awvalid_i = 1'b1; awaddr_i = 32'h8000_0000; awid_i = 6'h2A;
    bq.push_back(6'h2A);
    @(negedge clk);
    check_eq("miss2_awready", awready_o, 1'b1);
    tick();
    awvalid_i = 1'b0;
    tick();
    @(negedge clk);
    check_eq("drain_pre_rst", handle_error_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_handle", handle_error_o, 1'b0);
    check_eq("rst_async_berr", berr_valid_o, 1'b0);
    bq.delete();
    @(negedge clk);
    rst = 1'b0;
    hit(32'h2000_0010, 4'b0100, 4'b0100, "post_rst");

    tick();
    check_eq("dq_drained", dq.size(), 0);
    check_eq("bq_drained", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
